post_crc_scanner: RTL and testbench

- Parametrised successor to the constant-zero post-configuration CRC primitive model: computes a real CRC-32 over a streamed configuration readback and raises CRCERROR on mismatch against a golden value.
- Golden value comes either from a host load or is learned from the first complete scan.
- Sits between the readback frame source and the system-monitor/fault logic. Single clock domain.

---
 rtl/post_crc_scanner.sv | 150 +++++++++++++++
 tb/tb_post_crc_scanner.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_crc_scanner.sv
// Post-configuration CRC scanner: CRC-32 over a streamed readback, compared against
// a golden value that is either host-loaded or learned from the first complete scan.
module post_crc_scanner #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          SCAN_WORDS  = 1024,
   parameter logic [31:0] CRC_POLY    = 32'h04C11DB7,
   parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
   parameter bit          LEARN_FIRST = 1'b1,
   parameter int          CNT_WIDTH   = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  EN,
   input  logic [DATA_WIDTH-1:0] DIN,
   input  logic                  DIN_VALID,
   output logic                  DIN_READY,
   input  logic [31:0]           GOLDEN_CRC,
   input  logic                  GOLDEN_LOAD,
   input  logic                  CLR_ERR,
   output logic                  CRCERROR,
   output logic                  CRC_DONE,
   output logic [31:0]           CRC_VALUE,
   output logic                  GOLDEN_VALID,
   output logic [CNT_WIDTH-1:0]  SCAN_COUNT
);

   localparam int WCNT_W = (SCAN_WORDS > 1) ? $clog2(SCAN_WORDS) : 1;
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(SCAN_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [31:0]         crc_run;
   logic [WCNT_W-1:0]   word_cnt;
   logic [31:0]         golden;
   logic                accept;
   logic                seed;
   logic                in_check;
   logic                mismatch;

   // Whole word folded into the CRC in one cycle, most significant bit first.
   function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                            input logic [DATA_WIDTH-1:0] data);
      logic [31:0]           c;
      logic [DATA_WIDTH-1:0] d;
      c = crc_in;
      d = data;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (c[31] ^ d[DATA_WIDTH-1]) begin
            c = (c << 1) ^ CRC_POLY;
         end else begin
            c = c << 1;
         end
         d = d << 1;
      end
      return c;
   endfunction

   // A word presented while EN is low is ignored even though DIN_READY is still high.
   assign DIN_READY = (state == SCAN);
   assign accept    = DIN_VALID && DIN_READY && EN;
   assign in_check  = (state == CHECK);
   assign seed      = EN && ((state == IDLE) || (state == CHECK));
   assign mismatch  = in_check && GOLDEN_VALID && (crc_run != golden);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (EN) state_next = SCAN;
         end
         SCAN: begin
            if (!EN) begin
               state_next = IDLE;
            end else if (accept && (word_cnt == LAST_WORD)) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            state_next = EN ? SCAN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         crc_run  <= CRC_INIT;
         word_cnt <= '0;
      end else if (seed) begin
         crc_run  <= CRC_INIT;
         word_cnt <= '0;
      end else if (accept) begin
         crc_run  <= crc_step(crc_run, DIN);
         word_cnt <= word_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CRC_DONE   <= 1'b0;
         CRC_VALUE  <= '0;
         SCAN_COUNT <= '0;
      end else begin
         CRC_DONE <= in_check;
         if (in_check) begin
            CRC_VALUE <= crc_run;
            if (SCAN_COUNT != {CNT_WIDTH{1'b1}}) SCAN_COUNT <= SCAN_COUNT + 1'b1;
         end
      end
   end

   // A host load in the CHECK cycle lands after the compare and overrides any learn.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         golden       <= '0;
         GOLDEN_VALID <= 1'b0;
      end else if (GOLDEN_LOAD) begin
         golden       <= GOLDEN_CRC;
         GOLDEN_VALID <= 1'b1;
      end else if (in_check && !GOLDEN_VALID && LEARN_FIRST) begin
         golden       <= crc_run;
         GOLDEN_VALID <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CRCERROR <= 1'b0;
      end else if (mismatch) begin
         CRCERROR <= 1'b1;
      end else if (CLR_ERR) begin
         CRCERROR <= 1'b0;
      end
   end

endmodule

// File: tb/tb_post_crc_scanner.sv
// Bench for post_crc_scanner (8-bit words, 9-word scans, learning enabled, 2-bit scan counter)
// against a polynomial-division CRC model and a scoreboard of the expected outputs.
module tb_post_crc_scanner;

   localparam int          SW   = 9;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [71:0] REF_MSG = 72'h31_32_33_34_35_36_37_38_39;  // "123456789"
   localparam logic [71:0] BAD_MSG = 72'h31_32_33_34_35_36_37_38_38;  // "123456788"

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        din_valid = 1'b0;
   logic [31:0] golden_crc = 32'h0;
   logic        golden_load = 1'b0;
   logic        clr_err = 1'b0;
   logic        dut_ready;
   logic        crcerror;
   logic        crc_done;
   logic [31:0] crc_value;
   logic        golden_valid;
   logic [1:0]  scan_count;

   int total = 0;
   int bad = 0;
   int done_count = 0;

   logic [31:0] m_golden;
   logic        m_gv;
   logic        m_err;
   logic [31:0] m_crc;
   logic [1:0]  m_cnt;

   post_crc_scanner #(
      .DATA_WIDTH(8), .SCAN_WORDS(SW), .CRC_POLY(POLY), .CRC_INIT(32'hFFFFFFFF),
      .LEARN_FIRST(1'b1), .CNT_WIDTH(2)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .EN(en), .DIN(din), .DIN_VALID(din_valid),
      .DIN_READY(dut_ready), .GOLDEN_CRC(golden_crc), .GOLDEN_LOAD(golden_load),
      .CLR_ERR(clr_err), .CRCERROR(crcerror), .CRC_DONE(crc_done),
      .CRC_VALUE(crc_value), .GOLDEN_VALID(golden_valid), .SCAN_COUNT(scan_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (crc_done === 1'b1) done_count++;
   end

   // Remainder of x^32*M(x) mod P, with the seed XORed into the leading 32 message bits.
   function automatic logic [31:0] model_crc(input logic [71:0] msg);
      logic [103:0] v;
      v = {msg, 32'h0};
      v[103:72] = v[103:72] ^ 32'hFFFFFFFF;
      for (int k = 0; k < 72; k++) begin
         if (v[103]) v[103:71] = v[103:71] ^ {1'b1, POLY};
         v = v << 1;
      end
      return v[103:72];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      din_valid = 1'b0;
      golden_load = 1'b0;
      clr_err = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      m_golden = 32'h0;
      m_gv = 1'b0;
      m_err = 1'b0;
      m_crc = 32'h0;
      m_cnt = 2'd0;
   endtask

   task automatic load_golden(input logic [31:0] val);
      golden_crc = val;
      golden_load = 1'b1;
      step();
      golden_load = 1'b0;
      m_golden = val;
      m_gv = 1'b1;
      if (clr_err) m_err = 1'b0;
      total++;
      if (golden_valid !== 1'b1) begin
         bad++;
         $display("FAIL load_golden_valid: got %b want 1", golden_valid);
      end
   endtask

   // Streams one full scan and checks the CHECK cycle and the completion edge against the model.
   task automatic run_scan(input logic [71:0] msg, input bit toggle, input bit keep_en,
                           input bit load_at_check, input logic [31:0] load_val, output int cyc);
      logic [71:0] sh;
      int          idx;
      int          d0;
      bit          acc;
      logic [31:0] c;
      logic        mism;
      sh = msg;
      idx = 0;
      cyc = 0;
      en = 1'b1;
      if (clr_err) m_err = 1'b0;
      while (idx < SW && cyc < 200) begin
         din = sh[71:64];
         din_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         acc = din_valid && dut_ready;
         step();
         if (acc) begin
            idx++;
            sh = sh << 8;
         end
         cyc++;
      end
      din_valid = 1'b0;
      total++;
      if (idx != SW) begin
         bad++;
         $display("FAIL scan_timeout: got %0d words want %0d", idx, SW);
      end
      d0 = done_count;
      total++;
      if (dut_ready !== 1'b0 || crc_done !== 1'b0 || crcerror !== m_err) begin
         bad++;
         $display("FAIL check_cycle: got ready=%b done=%b err=%b want 0 0 %b",
                  dut_ready, crc_done, crcerror, m_err);
      end
      if (load_at_check) begin
         golden_crc = load_val;
         golden_load = 1'b1;
      end
      en = keep_en;
      step();
      golden_load = 1'b0;
      c = model_crc(msg);
      mism = m_gv && (c != m_golden);
      if (mism) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (!m_gv) begin
         m_golden = c;
         m_gv = 1'b1;
      end
      if (load_at_check) begin
         m_golden = load_val;
         m_gv = 1'b1;
      end
      m_crc = c;
      if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      total++;
      if (crc_done !== 1'b1) begin
         bad++;
         $display("FAIL done_latency: got %b want 1", crc_done);
      end
      total++;
      if (crc_value !== m_crc) begin
         bad++;
         $display("FAIL crc_value: got %h want %h", crc_value, m_crc);
      end
      total++;
      if (scan_count !== m_cnt || golden_valid !== m_gv || crcerror !== m_err) begin
         bad++;
         $display("FAIL scan_status: got cnt=%0d gv=%b err=%b want cnt=%0d gv=%b err=%b",
                  scan_count, golden_valid, crcerror, m_cnt, m_gv, m_err);
      end
      if (!keep_en) begin
         step();
         if (clr_err) m_err = 1'b0;
         total++;
         if (crc_done !== 1'b0 || done_count != d0 + 1 || crcerror !== m_err) begin
            bad++;
            $display("FAIL done_pulse: got done=%b pulses=%0d err=%b want 0 %0d %b",
                     crc_done, done_count - d0, crcerror, 1, m_err);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (crcerror !== 1'b0 || crc_done !== 1'b0 || dut_ready !== 1'b0 || golden_valid !== 1'b0
          || crc_value !== 32'h0 || scan_count !== 2'd0) begin
         bad++;
         $display("FAIL reset_state: got err=%b done=%b ready=%b gv=%b crc=%h cnt=%0d want all 0",
                  crcerror, crc_done, dut_ready, golden_valid, crc_value, scan_count);
      end
   endtask

   task automatic test_learn();
      int cyc;
      do_reset();
      run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crc_value !== 32'h0376E6E7 || golden_valid !== 1'b1 || scan_count !== 2'd1) begin
         bad++;
         $display("FAIL learn_check_value: got crc=%h gv=%b cnt=%0d want 0376e6e7 1 1",
                  crc_value, golden_valid, scan_count);
      end
   endtask

   task automatic test_mismatch_clear();
      int cyc;
      run_scan(BAD_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crcerror !== 1'b1) begin
         bad++;
         $display("FAIL mismatch_err: got %b want 1", crcerror);
      end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      m_err = 1'b0;
      total++;
      if (crcerror !== 1'b0) begin
         bad++;
         $display("FAIL clr_err: got %b want 0", crcerror);
      end
   endtask

   task automatic test_golden_load();
      int cyc;
      do_reset();
      load_golden(32'h0376E6E7);
      run_scan(REF_MSG, 1'b1, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crcerror !== 1'b0) begin
         bad++;
         $display("FAIL loaded_match_err: got %b want 0", crcerror);
      end
      do_reset();
      load_golden(32'hDEADBEEF);
      run_scan(REF_MSG, 1'b1, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crcerror !== 1'b1) begin
         bad++;
         $display("FAIL loaded_mismatch_err: got %b want 1", crcerror);
      end
   endtask

   task automatic test_abort();
      int          cyc;
      int          d0;
      logic [71:0] sh;
      do_reset();
      run_scan(BAD_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      d0 = done_count;
      sh = REF_MSG;
      en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         din = sh[71:64];
         din_valid = 1'b1;
         step();
         sh = sh << 8;
      end
      en = 1'b0;
      din = sh[71:64];
      step();
      din_valid = 1'b0;
      step();
      total++;
      if (dut_ready !== 1'b0 || done_count != d0 || scan_count !== m_cnt || crc_value !== m_crc) begin
         bad++;
         $display("FAIL abort_state: got ready=%b pulses=%0d cnt=%0d crc=%h want 0 0 %0d %h",
                  dut_ready, done_count - d0, scan_count, crc_value, m_cnt, m_crc);
      end
      run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crc_value !== 32'h0376E6E7 || scan_count !== 2'd2) begin
         bad++;
         $display("FAIL after_abort: got crc=%h cnt=%0d want 0376e6e7 2", crc_value, scan_count);
      end
   endtask

   task automatic test_reset_mid_scan();
      int          cyc;
      logic [71:0] sh;
      do_reset();
      load_golden(32'hDEADBEEF);
      run_scan(REF_MSG, 1'b0, 1'b1, 1'b0, 32'h0, cyc);
      sh = BAD_MSG;
      for (int i = 0; i < 5; i++) begin
         din = sh[71:64];
         din_valid = 1'b1;
         step();
         sh = sh << 8;
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (crcerror !== 1'b0 || crc_done !== 1'b0 || dut_ready !== 1'b0 || golden_valid !== 1'b0
          || crc_value !== 32'h0 || scan_count !== 2'd0) begin
         bad++;
         $display("FAIL async_reset: got err=%b done=%b ready=%b gv=%b crc=%h cnt=%0d want all 0",
                  crcerror, crc_done, dut_ready, golden_valid, crc_value, scan_count);
      end
      din_valid = 1'b0;
      en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      m_golden = 32'h0;
      m_gv = 1'b0;
      m_err = 1'b0;
      m_crc = 32'h0;
      m_cnt = 2'd0;
      run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      total++;
      if (crcerror !== 1'b0 || golden_valid !== 1'b1) begin
         bad++;
         $display("FAIL relearn: got err=%b gv=%b want 0 1", crcerror, golden_valid);
      end
   endtask

   task automatic test_set_wins_saturate();
      int cyc;
      do_reset();
      run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      clr_err = 1'b1;
      run_scan(BAD_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      clr_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      end
      total++;
      if (scan_count !== 2'd3) begin
         bad++;
         $display("FAIL saturate: got %0d want 3", scan_count);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      do_reset();
      run_scan(REF_MSG, 1'b0, 1'b1, 1'b0, 32'h0, cyc);
      run_scan(BAD_MSG, 1'b0, 1'b1, 1'b1, model_crc(BAD_MSG), cyc);
      total++;
      if (cyc != SW) begin
         bad++;
         $display("FAIL throughput_2: got %0d cycles want %0d", cyc, SW);
      end
      clr_err = 1'b1;
      run_scan(REF_MSG, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
      clr_err = 1'b0;
      total++;
      if (cyc != SW) begin
         bad++;
         $display("FAIL throughput_3: got %0d cycles want %0d", cyc, SW);
      end
   endtask

   task automatic test_random();
      int          cyc;
      logic [71:0] msg;
      bit          ld;
      logic [31:0] lv;
      do_reset();
      for (int it = 0; it < 12; it++) begin
         msg = ($urandom_range(0, 2) == 0) ? REF_MSG : {$urandom(), $urandom(), 8'($urandom())};
         ld = ($urandom_range(0, 3) == 0);
         lv = ($urandom_range(0, 1) == 0) ? 32'h0376E6E7 : $urandom();
         clr_err = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) load_golden($urandom());
         run_scan(msg, 1'($urandom_range(0, 1)), 1'b0, ld, lv, cyc);
         clr_err = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_learn();
      test_mismatch_clear();
      test_golden_load();
      test_abort();
      test_reset_mid_scan();
      test_set_wins_saturate();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
